alu_cond_unit: RTL and testbench



---
 rtl/alu_cond_pkg.sv | 34 +++
 rtl/cond_eval.sv | 42 ++++
 rtl/alu_cond_unit.sv | 117 +++++++++++
 tb/tb_alu_cond_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_cond_pkg.sv
// Shared types for the ALU condition unit: condition codes, flag bit positions
// and FSM states.
package alu_cond_pkg;

   typedef enum logic [3:0] {
      EQ   = 4'b0000,
      NE   = 4'b0001,
      CS   = 4'b0010,
      CC   = 4'b0011,
      MI   = 4'b0100,
      PL   = 4'b0101,
      VS   = 4'b0110,
      VC   = 4'b0111,
      HI   = 4'b1000,
      LS   = 4'b1001,
      GE   = 4'b1010,
      LT   = 4'b1011,
      GT   = 4'b1100,
      LE   = 4'b1101,
      AL   = 4'b1110,
      RSVD = 4'b1111
   } cond_e;

   localparam int unsigned FLG_N = 3;
   localparam int unsigned FLG_Z = 2;
   localparam int unsigned FLG_C = 1;
   localparam int unsigned FLG_V = 0;

   typedef enum logic {
      RUN,
      FLUSH
   } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: decides whether a condition passes
// against a flag vector and flags the reserved encoding.
module cond_eval
   import alu_cond_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] flags_i,
   output logic       pass_o,
   output logic       illegal_o
);

   logic n_flag, z_flag, c_flag, v_flag;

   assign n_flag = flags_i[FLG_N];
   assign z_flag = flags_i[FLG_Z];
   assign c_flag = flags_i[FLG_C];
   assign v_flag = flags_i[FLG_V];

   always_comb begin
      pass_o    = 1'b0;
      illegal_o = 1'b0;
      case (cond_e'(cond_i))
         EQ:      pass_o = z_flag;
         NE:      pass_o = !z_flag;
         CS:      pass_o = c_flag;
         CC:      pass_o = !c_flag;
         MI:      pass_o = n_flag;
         PL:      pass_o = !n_flag;
         VS:      pass_o = v_flag;
         VC:      pass_o = !v_flag;
         HI:      pass_o = c_flag && !z_flag;
         LS:      pass_o = !c_flag || z_flag;
         GE:      pass_o = (n_flag == v_flag);
         LT:      pass_o = (n_flag != v_flag);
         GT:      pass_o = !z_flag && (n_flag == v_flag);
         LE:      pass_o = z_flag || (n_flag != v_flag);
         AL:      pass_o = 1'b1;
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_cond_unit.sv
// Consumes ALU result/flags, maintains the flag register, resolves conditional
// execution and branches, and holds a fixed-length flush after a taken branch.
module alu_cond_unit
   import alu_cond_pkg::*;
#(
   parameter int unsigned N            = 8,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   cond,
   input  logic         flag_wr,
   input  logic         is_branch,
   input  logic [3:0]   alu_flags,
   input  logic [N-1:0] alu_result,
   output logic         out_valid,
   output logic         cond_ex,
   output logic [N-1:0] wb_result,
   output logic         branch_taken,
   output logic         flush,
   output logic         illegal_cond,
   output logic [3:0]   flags_q
);

   state_e         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [3:0]     flags_d;
   logic           out_valid_q, out_valid_d;
   logic           cond_ex_q, cond_ex_d;
   logic [N-1:0]   wb_result_q, wb_result_d;
   logic           branch_q, branch_d;
   logic           illegal_q, illegal_d;
   logic           pass, illegal, accept;

   // Evaluated against the flags from before this op; no bypass of alu_flags.
   cond_eval u_cond_eval (
      .cond_i    (cond),
      .flags_i   (flags_q),
      .pass_o    (pass),
      .illegal_o (illegal)
   );

   assign accept = in_valid && (state_q == RUN);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      flags_d     = flags_q;
      out_valid_d = 1'b0;
      cond_ex_d   = cond_ex_q;
      wb_result_d = wb_result_q;
      branch_d    = 1'b0;
      illegal_d   = 1'b0;

      if (accept) begin
         out_valid_d = 1'b1;
         cond_ex_d   = pass;
         wb_result_d = pass ? alu_result : '0;
         branch_d    = is_branch && pass;
         illegal_d   = illegal;
         if (flag_wr && pass) begin
            flags_d = alu_flags;
         end
      end

      case (state_q)
         RUN: begin
            if (accept && is_branch && pass) begin
               state_d = FLUSH;
               cnt_d   = 4'(FLUSH_CYCLES);
            end
         end
         FLUSH: begin
            if (cnt_q <= 4'd1) begin
               state_d = RUN;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         cnt_q       <= 4'd0;
         flags_q     <= 4'b0000;
         out_valid_q <= 1'b0;
         cond_ex_q   <= 1'b0;
         wb_result_q <= '0;
         branch_q    <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
         cond_ex_q   <= cond_ex_d;
         wb_result_q <= wb_result_d;
         branch_q    <= branch_d;
         illegal_q   <= illegal_d;
      end
   end

   assign in_ready     = (state_q == RUN);
   assign flush        = (state_q == FLUSH);
   assign out_valid    = out_valid_q;
   assign cond_ex      = cond_ex_q;
   assign wb_result    = wb_result_q;
   assign branch_taken = branch_q;
   assign illegal_cond = illegal_q;

endmodule

// File: tb/tb_alu_cond_unit.sv
// Directed bench for alu_cond_unit with hand-computed expectations.
module tb_alu_cond_unit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] cond;
   logic       flag_wr;
   logic       is_branch;
   logic [3:0] alu_flags;
   logic [7:0] alu_result;
   logic       out_valid;
   logic       cond_ex;
   logic [7:0] wb_result;
   logic       branch_taken;
   logic       flush;
   logic       illegal_cond;
   logic [3:0] flags_q;

   int n_cmp = 0;
   int n_err = 0;

   alu_cond_unit #(
      .N            (8),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .cond         (cond),
      .flag_wr      (flag_wr),
      .is_branch    (is_branch),
      .alu_flags    (alu_flags),
      .alu_result   (alu_result),
      .out_valid    (out_valid),
      .cond_ex      (cond_ex),
      .wb_result    (wb_result),
      .branch_taken (branch_taken),
      .flush        (flush),
      .illegal_cond (illegal_cond),
      .flags_q      (flags_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] c, input logic fw, input logic br,
                        input logic [3:0] fl, input logic [7:0] res);
      in_valid   = v;
      cond       = c;
      flag_wr    = fw;
      is_branch  = br;
      alu_flags  = fl;
      alu_result = res;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00);
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_cond_ex", 32'(cond_ex), 32'd0);
      chk("rst_wb", 32'(wb_result), 32'h00);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_flags", 32'(flags_q), 32'h0);
      rst_n = 1'b1;
      tick();

      // AL writes Z
      drive(1'b1, 4'b1110, 1'b1, 1'b0, 4'b0100, 8'h00);
      tick();
      chk("al_out_valid", 32'(out_valid), 32'd1);
      chk("al_cond_ex", 32'(cond_ex), 32'd1);
      chk("al_flags", 32'(flags_q), 32'h4);

      drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h2A);
      tick();
      chk("eq_cond_ex", 32'(cond_ex), 32'd1);
      chk("eq_wb", 32'(wb_result), 32'h2A);

      drive(1'b1, 4'b0001, 1'b1, 1'b0, 4'b1000, 8'h55);
      tick();
      chk("ne_out_valid", 32'(out_valid), 32'd1);
      chk("ne_cond_ex", 32'(cond_ex), 32'd0);
      chk("ne_wb", 32'(wb_result), 32'h00);
      chk("ne_flags", 32'(flags_q), 32'h4);

      drive(1'b1, 4'b1110, 1'b1, 1'b0, 4'b1000, 8'h00);
      tick();
      chk("set_n_flags", 32'(flags_q), 32'h8);
      drive(1'b1, 4'b1011, 1'b0, 1'b0, 4'b0000, 8'h11);
      tick();
      chk("lt_cond_ex", 32'(cond_ex), 32'd1);
      chk("lt_wb", 32'(wb_result), 32'h11);
      drive(1'b1, 4'b1010, 1'b0, 1'b0, 4'b0000, 8'h22);
      tick();
      chk("ge_cond_ex", 32'(cond_ex), 32'd0);
      chk("ge_wb", 32'(wb_result), 32'h00);

      drive(1'b1, 4'b1110, 1'b1, 1'b0, 4'b0000, 8'h00);
      tick();
      chk("clr_flags", 32'(flags_q), 32'h0);
      drive(1'b1, 4'b1100, 1'b0, 1'b0, 4'b0000, 8'h33);
      tick();
      chk("gt_cond_ex", 32'(cond_ex), 32'd1);
      chk("gt_wb", 32'(wb_result), 32'h33);
      drive(1'b0, 4'b1110, 1'b1, 1'b0, 4'b1111, 8'hFF);
      tick();
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_cond_ex_hold", 32'(cond_ex), 32'd1);
      chk("idle_wb_hold", 32'(wb_result), 32'h33);
      chk("idle_flags_hold", 32'(flags_q), 32'h0);
      drive(1'b1, 4'b1101, 1'b0, 1'b0, 4'b0000, 8'h44);
      tick();
      chk("le_cond_ex", 32'(cond_ex), 32'd0);

      // Taken branch, then in_valid held through flush
      drive(1'b1, 4'b1110, 1'b1, 1'b0, 4'b0100, 8'h00);
      tick();
      drive(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 8'h66);
      tick();
      chk("br_taken", 32'(branch_taken), 32'd1);
      chk("br_flush1", 32'(flush), 32'd1);
      chk("br_ready1", 32'(in_ready), 32'd0);
      chk("br_cond_ex", 32'(cond_ex), 32'd1);
      drive(1'b1, 4'b1110, 1'b1, 1'b0, 4'b1000, 8'h77);
      tick();
      chk("br_pulse_end", 32'(branch_taken), 32'd0);
      chk("br_flush2", 32'(flush), 32'd1);
      chk("br_ready2", 32'(in_ready), 32'd0);
      chk("br_no_out1", 32'(out_valid), 32'd0);
      tick();
      chk("br_flush_done", 32'(flush), 32'd0);
      chk("br_ready_back", 32'(in_ready), 32'd1);
      chk("br_no_out2", 32'(out_valid), 32'd0);
      chk("br_flags_kept", 32'(flags_q), 32'h4);
      tick();
      chk("resume_out_valid", 32'(out_valid), 32'd1);
      chk("resume_wb", 32'(wb_result), 32'h77);
      chk("resume_flags", 32'(flags_q), 32'h8);

      // Reserved condition
      drive(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 8'h99);
      tick();
      chk("rsvd_illegal", 32'(illegal_cond), 32'd1);
      chk("rsvd_cond_ex", 32'(cond_ex), 32'd0);
      chk("rsvd_flush", 32'(flush), 32'd0);
      chk("rsvd_branch", 32'(branch_taken), 32'd0);
      chk("rsvd_flags", 32'(flags_q), 32'h8);
      drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);
      tick();
      chk("rsvd_pulse_end", 32'(illegal_cond), 32'd0);

      // Non-passing branch (Z=0)
      drive(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 8'hAA);
      tick();
      chk("nbr_out_valid", 32'(out_valid), 32'd1);
      chk("nbr_cond_ex", 32'(cond_ex), 32'd0);
      chk("nbr_branch", 32'(branch_taken), 32'd0);
      chk("nbr_flush", 32'(flush), 32'd0);

      // Branch with flag write, then reset during flush
      drive(1'b1, 4'b0100, 1'b1, 1'b1, 4'b0010, 8'hBB);
      tick();
      chk("fwbr_flush", 32'(flush), 32'd1);
      chk("fwbr_flags", 32'(flags_q), 32'h2);
      drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_flush", 32'(flush), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_flags", 32'(flags_q), 32'h0);
      chk("mid_rst_branch", 32'(branch_taken), 32'd0);
      tick();
      rst_n = 1'b1;
      drive(1'b1, 4'b1110, 1'b1, 1'b0, 4'b0100, 8'hCC);
      tick();
      chk("post_rst_out_valid", 32'(out_valid), 32'd1);
      chk("post_rst_wb", 32'(wb_result), 32'hCC);
      chk("post_rst_flags", 32'(flags_q), 32'h4);
      chk("post_rst_flush", 32'(flush), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
